// File: rtl/resp_fifo_arb.sv
// Round-robin arbiter sharing one response FIFO between NUM_REQ burst sources.
// A burst is granted only when the FIFO has room for all of its beats.
module resp_fifo_arb #(
  parameter int WIDTH   = 64,
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 3,
  parameter int LEN_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         beat_ready,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       fifo_wr,
  output logic [WIDTH-1:0]           fifo_w_data,
  input  logic                       fifo_full,
  input  logic                       fifo_rd,
  input  logic                       fifo_empty,
  output logic [DEPTH:0]             occupancy,
  output logic                       busy,
  output logic [NUM_REQ-1:0]         len_err
);

  localparam int CAP   = 2 ** DEPTH;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW    = (LEN_W > DEPTH + 1) ? LEN_W : DEPTH + 1;

  localparam logic [DEPTH:0]   OCC_CAP  = (DEPTH + 1)'(CAP);
  localparam logic [DEPTH:0]   OCC_ONE  = (DEPTH + 1)'(1);
  localparam logic [CW-1:0]    LEN_CAP  = CW'(CAP);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [LEN_W-1:0]     beats_left_q, beats_left_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DEPTH:0]       occ_q, occ_d;
  logic [NUM_REQ-1:0]   len_err_q, len_err_d;

  logic [CW-1:0]        free_cnt;
  logic [CW-1:0]        len_ext;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   illegal;
  logic                 pick_found;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [LEN_W-1:0]     pick_len;
  logic [IDX_W-1:0]     owner_idx;
  logic [IDX_W-1:0]     next_rr;
  logic                 beat_acc;
  logic                 rd_acc;
  logic [WIDTH-1:0]     wr_data;

  // Write path: purely combinational from grant, req_valid and fifo_full.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    beat_acc  = (|(grant_q & req_valid)) & ~fifo_full;
    wr_data   = '0;
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx = IDX_W'(i);
        if (beat_acc) wr_data = req_data[i*WIDTH +: WIDTH];
      end
    end
    next_rr = (owner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : owner_idx + IDX_W'(1);
  end

  // Eligibility uses the registered occupancy, never the same-cycle read.
  always_comb begin
    free_cnt = LEN_CAP - CW'(occ_q);
    len_ext  = '0;
    eligible = '0;
    illegal  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      len_ext     = CW'(req_len[i*LEN_W +: LEN_W]);
      illegal[i]  = req_valid[i] & ((len_ext == '0) | (len_ext > LEN_CAP));
      eligible[i] = req_valid[i] & (len_ext != '0) & (len_ext <= free_cnt);
    end
  end

  // Rotating priority: indices at or above rr_ptr first, then the wrapped ones.
  always_comb begin
    pick_found  = 1'b0;
    pick_onehot = '0;
    pick_len    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && eligible[i] && (IDX_W'(i) >= rr_ptr_q)) begin
        pick_found     = 1'b1;
        pick_onehot[i] = 1'b1;
        pick_len       = req_len[i*LEN_W +: LEN_W];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && eligible[i]) begin
        pick_found     = 1'b1;
        pick_onehot[i] = 1'b1;
        pick_len       = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Occupancy tracks observed writes and reads, saturating at 0 and CAP.
  always_comb begin
    rd_acc = fifo_rd & ~fifo_empty;
    occ_d  = occ_q;
    if (beat_acc && !rd_acc && (occ_q != OCC_CAP)) begin
      occ_d = occ_q + OCC_ONE;
    end else if (rd_acc && !beat_acc && (occ_q != '0)) begin
      occ_d = occ_q - OCC_ONE;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    beats_left_d = beats_left_q;
    rr_ptr_d     = rr_ptr_q;
    len_err_d    = len_err_q;
    case (state_q)
      ST_IDLE: begin
        len_err_d = len_err_q | illegal;
        if (pick_found) begin
          state_d      = ST_BURST;
          grant_d      = pick_onehot;
          beats_left_d = pick_len;
        end
      end
      ST_BURST: begin
        if (beat_acc) begin
          if (beats_left_q == LEN_ONE) begin
            state_d      = ST_IDLE;
            grant_d      = '0;
            beats_left_d = '0;
            rr_ptr_d     = next_rr;
          end else begin
            beats_left_d = beats_left_q - LEN_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      beats_left_q <= '0;
      rr_ptr_q     <= '0;
      occ_q        <= '0;
      len_err_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      grant_q      <= grant_d;
      beats_left_q <= beats_left_d;
      rr_ptr_q     <= rr_ptr_d;
      occ_q        <= occ_d;
      len_err_q    <= len_err_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q == ST_BURST);
  assign beat_ready  = grant_q & {NUM_REQ{~fifo_full}};
  assign fifo_wr     = beat_acc;
  assign fifo_w_data = wr_data;
  assign occupancy   = occ_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_resp_fifo_arb.sv
// Bench for resp_fifo_arb: directed scenarios plus random traffic, all compared
// cycle by cycle against a transaction-level arbiter model and a queue-based FIFO.
module tb_resp_fifo_arb;

  localparam int N   = 4;
  localparam int W   = 64;
  localparam int D   = 3;
  localparam int LW  = 4;
  localparam int CAP = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*LW-1:0]  req_len = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     beat_ready;
  logic [N-1:0]     grant;
  logic             fifo_wr;
  logic [W-1:0]     fifo_w_data;
  logic             fifo_full = 1'b0;
  logic             fifo_rd = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [D:0]       occupancy;
  logic             busy;
  logic [N-1:0]     len_err;

  resp_fifo_arb #(.WIDTH(W), .NUM_REQ(N), .DEPTH(D), .LEN_W(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_len     (req_len),
    .req_data    (req_data),
    .beat_ready  (beat_ready),
    .grant       (grant),
    .fifo_wr     (fifo_wr),
    .fifo_w_data (fifo_w_data),
    .fifo_full   (fifo_full),
    .fifo_rd     (fifo_rd),
    .fifo_empty  (fifo_empty),
    .occupancy   (occupancy),
    .busy        (busy),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  // The FIFO the block feeds, and the reference arbiter state.
  logic [W-1:0] fifo_q[$];
  int           m_owner;
  int           m_left;
  int           m_rr;
  int           m_occ;
  logic [N-1:0] m_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic last_wr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*LW-1:0] lens(input int a, input int b, input int c, input int e);
    return {LW'(e), LW'(c), LW'(b), LW'(a)};
  endfunction

  function automatic logic [N*W-1:0] rnd_data();
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N * W / 32; i++) r = (r << 32) | (N*W)'($urandom);
    return r;
  endfunction

  function automatic int len_of(input logic [N*LW-1:0] l, input int i);
    return int'((l >> (i * LW)) & (N*LW)'(4'hF));
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_left  = 0;
    m_rr    = 0;
    m_occ   = 0;
    m_err   = '0;
    fifo_q.delete();
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, then advance both.
  task automatic step(input logic [N-1:0] v, input logic [N*LW-1:0] l,
                      input logic [N*W-1:0] d, input logic rd);
    logic [N-1:0] eg;
    logic         ew;
    logic [W-1:0] ed;
    logic         act_wr;
    logic [W-1:0] act_data;
    logic         rd_acc;
    int           free;
    int           li;
    int           g;
    @(negedge clk);
    req_valid  = v;
    req_len    = l;
    req_data   = d;
    fifo_rd    = rd;
    fifo_full  = (fifo_q.size() >= CAP);
    fifo_empty = (fifo_q.size() == 0);
    #1;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    ew = (m_owner >= 0) && (((v >> m_owner) & N'(1)) != '0) && !fifo_full;
    ed = ew ? W'(d >> (m_owner * W)) : '0;
    check("grant", grant, eg);
    check("busy", busy, m_owner >= 0);
    check("beat_ready", beat_ready, fifo_full ? '0 : eg);
    check("fifo_wr", fifo_wr, ew);
    check("w_data", fifo_w_data, ed);
    check("occupancy", occupancy, m_occ);
    check("fifo_count", occupancy, fifo_q.size());
    check("len_err", len_err, m_err);
    if (busy) check("full_in_burst", fifo_full, 1'b0);
    act_wr   = fifo_wr;
    act_data = fifo_w_data;
    last_wr  = fifo_wr;
    @(posedge clk);
    rd_acc = rd && !fifo_empty;
    if (rd_acc) void'(fifo_q.pop_front());
    if (act_wr) fifo_q.push_back(act_data);
    free  = CAP - m_occ;
    m_occ = m_occ + (ew ? 1 : 0) - (rd_acc ? 1 : 0);
    if (m_occ < 0) m_occ = 0;
    if (m_occ > CAP) m_occ = CAP;
    if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        li = len_of(l, i);
        if (v[i] && (li == 0 || li > CAP)) m_err[i] = 1'b1;
      end
      for (int k = 0; k < N; k++) begin
        g  = (m_rr + k) % N;
        li = len_of(l, g);
        if (m_owner < 0 && v[g] && li >= 1 && li <= free) begin
          m_owner = g;
          m_left  = li;
        end
      end
    end else if (ew) begin
      m_left--;
      if (m_left == 0) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  // Asserts reset wherever the cycle currently is and checks outputs drop at once.
  task automatic apply_reset();
    #2;
    reset     = 1'b0;
    req_valid = '0;
    fifo_rd   = 1'b0;
    #1;
    check("rst_grant", grant, '0);
    check("rst_beat_ready", beat_ready, '0);
    check("rst_fifo_wr", fifo_wr, 1'b0);
    check("rst_w_data", fifo_w_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_occupancy", occupancy, '0);
    check("rst_len_err", len_err, '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int  wr_cnt;
    bit  seen0;
    bit  seen3;
    logic [N-1:0] stall_v [8];
    model_reset();
    apply_reset();

    // Single burst: requester 2, length 3.
    for (int c = 0; c < 4; c++) begin
      step(4'b0100, lens(0, 0, 3, 0), rnd_data(), 1'b0);
      if (c == 0) begin
        #1;
        check("single_grant", grant, 4'b0100);
      end
    end
    #1;
    check("single_occ", occupancy, 3);
    check("single_busy", busy, 1'b0);
    step('0, '0, '0, 1'b0);

    // Round-robin fairness with four single-beat requesters.
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      step(4'hF, lens(1, 1, 1, 1), rnd_data(), 1'b0);
      #1;
      check("rr_grant", grant, (c % 2 == 0) ? (N'(1) << (c / 2)) : '0);
    end
    step('0, '0, '0, 1'b0);
    #1;
    check("rr_occ", occupancy, 4);

    // Space reservation: occupancy 6, requester 0 needs 3, requester 1 needs 2.
    apply_reset();
    for (int c = 0; c < 7; c++) step(4'b0100, lens(0, 0, 6, 0), rnd_data(), 1'b0);
    step(4'b0011, lens(3, 2, 0, 0), rnd_data(), 1'b0);
    #1;
    check("space_first", grant, 4'b0010);
    seen0 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step(4'b0011, lens(3, 2, 0, 0), rnd_data(), c >= 2);
      #1;
      if (grant == 4'b0001) seen0 = 1'b1;
    end
    check("space_r0_granted", seen0, 1'b1);

    // Mid-burst stall with a read every cycle.
    apply_reset();
    for (int c = 0; c < 4; c++) step(4'b0100, lens(0, 0, 3, 0), rnd_data(), 1'b0);
    stall_v = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    wr_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step(stall_v[c], lens(0, 4, 0, 0), rnd_data(), 1'b1);
      if (last_wr) wr_cnt++;
    end
    check("stall_writes", wr_cnt, 4);

    // Illegal lengths on requester 3 (0, then 9).
    apply_reset();
    seen0 = 1'b0;
    seen3 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step(4'b1001, lens(1, 0, 0, (c < 4) ? 0 : 9), rnd_data(), 1'b1);
      #1;
      if (grant[0]) seen0 = 1'b1;
      if (grant[3]) seen3 = 1'b1;
    end
    check("illegal_err", len_err, 4'b1000);
    check("illegal_no_grant", seen3, 1'b0);
    check("illegal_other_granted", seen0, 1'b1);

    // Reset during beat 2 of a length-5 burst.
    apply_reset();
    step(4'b0010, lens(0, 5, 0, 0), rnd_data(), 1'b0);
    step(4'b0010, lens(0, 5, 0, 0), rnd_data(), 1'b0);
    #1;
    check("pre_rst_wr", fifo_wr, 1'b1);
    apply_reset();
    step(4'hF, lens(1, 1, 1, 1), rnd_data(), 1'b0);
    #1;
    check("post_rst_grant", grant, 4'b0001);

    // Random traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      logic [N-1:0]    v;
      logic [N*LW-1:0] l;
      int              r;
      int              li;
      v = '0;
      l = '0;
      for (int i = 0; i < N; i++) begin
        if (i == m_owner) v = v | (N'($urandom_range(0, 4) != 0) << i);
        else              v = v | (N'($urandom_range(0, 1)) << i);
        r  = $urandom_range(0, 19);
        li = (r < 18) ? 1 + (r % 8) : ((r == 18) ? 0 : $urandom_range(9, 15));
        l  = l | ((N*LW)'(li) << (i * LW));
      end
      step(v, l, rnd_data(), $urandom_range(0, 99) < 45);
      if ($urandom_range(0, 399) == 0) apply_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/resp_fifo_arb.md
# resp_fifo_arb

Round-robin arbiter that shares one response FIFO (WIDTH-bit entries, 2**DEPTH deep) between NUM_REQ response sources. Each requester announces a burst length. A burst is granted only when the FIFO has room for the whole burst, so a granted burst never stalls on a full FIFO. The block drives the FIFO write side and keeps its own occupancy count from observed writes and reads.

## Interface
Parameters:
- WIDTH, 64, data width of one response beat / FIFO entry
- NUM_REQ, 4, number of requesters (2..8)
- DEPTH, 3, log2 of FIFO capacity; capacity CAP = 2**DEPTH
- LEN_W, 4, width of each burst-length field; must satisfy 2**LEN_W > CAP

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has a beat / burst pending; held high for the whole burst
- req_len  in  NUM_REQ*LEN_W  burst length of requester i, field i at [i*LEN_W +: LEN_W]; sampled only at grant
- req_data  in  NUM_REQ*WIDTH  beat data of requester i, field i at [i*WIDTH +: WIDTH]
- beat_ready  out  NUM_REQ  one-hot; beat of requester i is accepted when req_valid[i] & beat_ready[i]
- grant  out  NUM_REQ  one-hot registered owner of the current burst; 0 when idle
- fifo_wr  out  1  FIFO write strobe
- fifo_w_data  out  WIDTH  FIFO write data
- fifo_full  in  1  FIFO full flag (safety interlock only)
- fifo_rd  in  1  consumer read strobe as applied to the FIFO
- fifo_empty  in  1  FIFO empty flag
- occupancy  out  DEPTH+1  entries held in the FIFO per internal count
- busy  out  1  burst in progress
- len_err  out  NUM_REQ  sticky, requester i presented an illegal length

## Operation
- Read accepted: rd_acc = fifo_rd & ~fifo_empty. Write accepted: wr_acc = fifo_wr.
- occupancy update each cycle: occupancy + wr_acc - rd_acc. free = CAP - occupancy.
- Eligible requester i: req_valid[i] is high, and 1 <= req_len[i] <= free.
- Illegal length: req_len[i] == 0 or req_len[i] > CAP while req_valid[i] is high in IDLE.
  - Sets len_err[i]; the bit clears only on reset.
  - An illegal requester is never granted.
- Two-state FSM:
  - IDLE:
    - If any requester is eligible, pick the first eligible index searching upward from rr_ptr, with wrap.
    - Register grant[g] = 1, beats_left = req_len[g], go to BURST.
    - Otherwise stay in IDLE.
  - BURST:
    - beat_ready = grant & {NUM_REQ{~fifo_full}}.
    - fifo_wr = req_valid[g] & ~fifo_full.
    - fifo_w_data = req_data field g; when fifo_wr = 0, fifo_w_data is 0.
    - Each accepted beat decrements beats_left.
    - Accepted beat with beats_left == 1: go to IDLE, grant = 0, rr_ptr = (g+1) mod NUM_REQ.
    - req_valid[g] low mid-burst: stall; no write, no state change, no abort.
- In IDLE, beat_ready = 0 and fifo_wr = 0.
- busy = (state == BURST).
- Reads may occur in any state and only increase free. Because free is checked at grant, fifo_full must never be seen high in BURST; if it is, the beat simply stalls.
- Occupancy saturates: it never goes below 0 or above CAP.

## Timing
- Reset values: grant = 0, beat_ready = 0, fifo_wr = 0, fifo_w_data = 0, busy = 0, occupancy = 0, len_err = 0, rr_ptr = 0, beats_left = 0, state = IDLE.
- Reset is asynchronous at assertion. Reset mid-burst abandons the burst; no partial-burst recovery.
- Grant latency: a request eligible in IDLE in cycle n is granted in cycle n+1, and its first beat can write in cycle n+1.
- beat_ready and fifo_wr are combinational from grant, req_valid and fifo_full; there is no added register stage on the write path.
- Throughput:
  - A burst of L beats with req_valid held high occupies L BURST cycles.
  - There is one IDLE cycle between consecutive bursts.
  - Peak rate is L/(L+1).
- Eligibility uses the occupancy register value in cycle n, not the same-cycle read. A read in cycle n makes free grow from cycle n+1.
- Simultaneous wr_acc and rd_acc: occupancy is unchanged.
- req_len is ignored after grant, so changes during a burst have no effect.

## Test plan
- Single burst: requester 2 with len 3, FIFO empty, consumer idle.
  - grant = 4'b0100 one cycle after the request.
  - fifo_wr high for 3 cycles with req_data[2] beats in order.
  - occupancy 0 → 3, busy drops, rr_ptr = 3.
- Round-robin fairness: all 4 requesters valid, each with len 1, no reads.
  - Grant order is 0, 1, 2, 3.
  - Each grant is separated by one IDLE cycle; occupancy ends at 4.
- Space reservation: occupancy = 6 (CAP = 8), requester 0 with len 3, requester 1 with len 2.
  - Requester 1 is granted first.
  - Requester 0 is granted only after enough reads that occupancy ≤ 5.
  - fifo_full is never high during BURST.
- Mid-burst stall plus concurrent read: requester 1 with len 4 drops req_valid for 2 cycles after beat 2, while fifo_rd is pulsed each cycle.
  - No write occurs during the stall; the burst completes with exactly 4 writes.
  - occupancy tracks writes minus reads exactly.
- Illegal length: requester 3 with len 0, then with len 9.
  - len_err[3] is set; requester 3 is never granted.
  - The other requesters are granted normally.
- Reset mid-burst: assert reset during beat 2 of a len-5 burst.
  - All outputs return to reset values immediately.
  - After release, a new request is granted starting from requester 0.
